// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported unified memory between the instruction-fetch
//   path and the load/store path. Each granted access walks
//   IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP -> IDLE, returns read
//   data with a one-cycle acknowledge, and drives cpu_stall while a
//   request is outstanding.
//
// Ports
//   clk, reset          : rising-edge clock, asynchronous active-low reset
//   if_req/if_addr      : fetch request (level, held until if_ack)
//   if_ack/if_rdata     : fetch done pulse and fetched instruction
//   d_req/d_we/d_type/d_addr/d_wdata : data request (level, held until d_ack)
//   d_ack/d_rdata       : data done pulse and load data
//   mem_en/mem_we/mem_type/mem_addr/mem_wdata : memory macro command
//   mem_rdata           : memory read data, valid MEM_LAT cycles after issue
//   busy                : arbiter not idle
//   cpu_stall           : a request is pending and not being acknowledged
module mem_port_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MEM_LAT         = 1,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_type,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [2:0]        mem_type,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              cpu_stall
);

  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
  localparam logic [3:0] LAT = 4'(MEM_LAT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t               state_reg, state_next;
  logic                 grant_data, grant_fetch;
  logic [STREAK_W-1:0]  streak_reg;
  logic [3:0]           wait_cnt_reg;
  logic                 sel_data_reg;  // 1 = current access belongs to the data port
  logic                 store_reg;     // current access is a store

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and arbitration. Requests are only looked at in IDLE, so a
  // requester still holding req during its RESP cycle is never re-granted.
  always_comb begin
    state_next  = state_reg;
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    case (state_reg)
      IDLE: begin
        if (d_req && (!if_req || (streak_reg < STREAK_MAX))) begin
          grant_data = 1'b1;
          state_next = ISSUE;
        end else if (if_req) begin
          grant_fetch = 1'b1;
          state_next  = ISSUE;
        end
      end
      ISSUE:   state_next = WAIT;
      WAIT:    if (wait_cnt_reg == 4'd1) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: command latch, wait counter, read-data capture and acks.
  // All memory-side and ack outputs are registered; strobes default low so
  // each is a single-cycle pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak_reg   <= '0;
      wait_cnt_reg <= '0;
      sel_data_reg <= 1'b0;
      store_reg    <= 1'b0;
      if_ack       <= 1'b0;
      d_ack        <= 1'b0;
      if_rdata     <= '0;
      d_rdata      <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_type     <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_data) begin
            sel_data_reg <= 1'b1;
            store_reg    <= d_we;
            mem_en       <= 1'b1;
            mem_we       <= d_we;
            mem_type     <= d_type;
            mem_addr     <= d_addr;
            mem_wdata    <= d_wdata;
            // Only a data grant that actually makes fetch wait counts
            // towards the streak; saturate so the fetch stays forced.
            if (if_req && (streak_reg < STREAK_MAX))
              streak_reg <= streak_reg + 1'b1;
          end else if (grant_fetch) begin
            sel_data_reg <= 1'b0;
            store_reg    <= 1'b0;
            mem_en       <= 1'b1;
            mem_type     <= 3'b010;
            mem_addr     <= if_addr;
            streak_reg   <= '0;
          end
        end
        ISSUE: wait_cnt_reg <= LAT;
        WAIT: begin
          wait_cnt_reg <= wait_cnt_reg - 1'b1;
          if (wait_cnt_reg == 4'd1) begin
            if (!sel_data_reg) begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end else begin
              if (!store_reg) d_rdata <= mem_rdata;
              d_ack <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_reg != IDLE);
  assign cpu_stall = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        if_req_v [2];
  logic        d_req_v  [2];
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        d_we;
  logic [2:0]  d_type;
  logic [31:0] mem_rdata_v [2];

  logic        if_ack_w [2], d_ack_w [2], mem_en_w [2], mem_we_w [2];
  logic        busy_w [2], cpu_stall_w [2];
  logic [31:0] if_rdata_w [2], d_rdata_w [2], mem_addr_w [2], mem_wdata_w [2];
  logic [2:0]  mem_type_w [2];

  // Instance 0 runs with MEM_LAT = 1, instance 1 with MEM_LAT = 3.
  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LAT((gi == 0) ? 1 : 3), .MAX_DATA_STREAK(4)
    ) u_dut (
      .clk(clk), .reset(rst_n),
      .if_req(if_req_v[gi]), .if_addr(if_addr),
      .if_ack(if_ack_w[gi]), .if_rdata(if_rdata_w[gi]),
      .d_req(d_req_v[gi]), .d_we(d_we), .d_type(d_type),
      .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack_w[gi]), .d_rdata(d_rdata_w[gi]),
      .mem_en(mem_en_w[gi]), .mem_we(mem_we_w[gi]), .mem_type(mem_type_w[gi]),
      .mem_addr(mem_addr_w[gi]), .mem_wdata(mem_wdata_w[gi]),
      .mem_rdata(mem_rdata_v[gi]),
      .busy(busy_w[gi]), .cpu_stall(cpu_stall_w[gi])
    );
  end

  typedef struct {
    int          dut;
    logic        is_d;
    logic        we;
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;     // value the memory returns in the valid cycle
    int          exp_lat;   // expected req-to-ack distance in cycles
    logic [2:0]  exp_type;  // expected mem_type on the issue cycle
  } vec_t;

  vec_t        tab [7];
  int          errors = 0;
  int          checks = 0;
  int          age [2];
  logic [31:0] resp_val;
  logic [31:0] exp_ird [2];
  logic [31:0] exp_drd [2];

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Advance to the next negedge and update the memory model: it returns
  // resp_val only in the cycle exactly MEM_LAT after mem_en, garbage elsewhere.
  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (mem_en_w[d]) age[d] = 0;
      else if (age[d] < 100) age[d]++;
      mem_rdata_v[d] = (age[d] == lat(d)) ? resp_val : (32'hBAD0_0000 | 32'(age[d]));
    end
  endtask

  task automatic check_zero(input int d, input string tag);
    chk({tag, ".if_ack"},    32'(if_ack_w[d]),    32'h0);
    chk({tag, ".d_ack"},     32'(d_ack_w[d]),     32'h0);
    chk({tag, ".if_rdata"},  if_rdata_w[d],       32'h0);
    chk({tag, ".d_rdata"},   d_rdata_w[d],        32'h0);
    chk({tag, ".mem_en"},    32'(mem_en_w[d]),    32'h0);
    chk({tag, ".mem_we"},    32'(mem_we_w[d]),    32'h0);
    chk({tag, ".mem_type"},  32'(mem_type_w[d]),  32'h0);
    chk({tag, ".mem_addr"},  mem_addr_w[d],       32'h0);
    chk({tag, ".mem_wdata"}, mem_wdata_w[d],      32'h0);
    chk({tag, ".busy"},      32'(busy_w[d]),      32'h0);
    chk({tag, ".cpu_stall"}, 32'(cpu_stall_w[d]), 32'h0);
  endtask

  task automatic run_txn(input int id, input vec_t v);
    int d, en_first, en_cnt, ack_at, stall_bad, wrong_ack;
    logic [31:0] iss_addr, iss_wd, hold_addr, ird, drd;
    logic [2:0]  iss_type;
    logic        iss_we, stall_ack, busy_ack;
    string t;
    d = v.dut;
    en_first = -1; en_cnt = 0; ack_at = -1; stall_bad = 0; wrong_ack = 0;
    iss_addr = '0; iss_wd = '0; hold_addr = '0; ird = '0; drd = '0;
    iss_type = '0; iss_we = 1'b0; stall_ack = 1'b1; busy_ack = 1'b0;
    t = $sformatf("txn%0d", id);
    step();
    // The idle port's address differs so a wrong address mux is visible.
    if_addr  = v.is_d ? ~v.addr : v.addr;
    d_addr   = v.is_d ? v.addr : ~v.addr;
    d_we     = v.we;
    d_type   = v.typ;
    d_wdata  = v.wdata;
    resp_val = v.rdata;
    if (v.is_d) d_req_v[d] = 1'b1;
    else        if_req_v[d] = 1'b1;
    for (int k = 1; k <= 20 && ack_at < 0; k++) begin
      step();
      if (mem_en_w[d]) begin
        en_cnt++;
        if (en_first < 0) begin
          en_first = k;
          iss_addr = mem_addr_w[d];
          iss_type = mem_type_w[d];
          iss_we   = mem_we_w[d];
          iss_wd   = mem_wdata_w[d];
        end
      end
      if (v.is_d ? if_ack_w[d] : d_ack_w[d]) wrong_ack++;
      if (v.is_d ? d_ack_w[d] : if_ack_w[d]) begin
        ack_at    = k;
        stall_ack = cpu_stall_w[d];
        busy_ack  = busy_w[d];
        hold_addr = mem_addr_w[d];
        ird       = if_rdata_w[d];
        drd       = d_rdata_w[d];
      end else if (!cpu_stall_w[d]) begin
        stall_bad++;
      end
    end
    if_req_v[d] = 1'b0;
    d_req_v[d]  = 1'b0;
    if (!v.is_d)   exp_ird[d] = v.rdata;
    else if (!v.we) exp_drd[d] = v.rdata;
    chk({t, ".en_offset"}, 32'(en_first), 32'd1);
    chk({t, ".en_cycles"}, 32'(en_cnt), 32'd1);
    chk({t, ".issue_we"}, 32'(iss_we), 32'(v.we));
    chk({t, ".issue_addr"}, iss_addr, v.addr);
    chk({t, ".issue_type"}, 32'(iss_type), 32'(v.exp_type));
    if (v.is_d && v.we) chk({t, ".issue_wdata"}, iss_wd, v.wdata);
    chk({t, ".ack_offset"}, 32'(ack_at), 32'(v.exp_lat));
    chk({t, ".wrong_ack"}, 32'(wrong_ack), 32'd0);
    chk({t, ".stall_before_ack"}, 32'(stall_bad), 32'd0);
    chk({t, ".stall_at_ack"}, 32'(stall_ack), 32'd0);
    chk({t, ".busy_at_ack"}, 32'(busy_ack), 32'd1);
    chk({t, ".addr_hold"}, hold_addr, v.addr);
    chk({t, ".if_rdata"}, ird, exp_ird[d]);
    chk({t, ".d_rdata"}, drd, exp_drd[d]);
    step();
    chk({t, ".ack_pulse"}, 32'(if_ack_w[d] | d_ack_w[d]), 32'd0);
    chk({t, ".busy_after"}, 32'(busy_w[d]), 32'd0);
    $display("txn %0d dut=%0d %s addr=%h ack_at=%0d rdata if=%h d=%h",
             id, d, v.is_d ? (v.we ? "store" : "load") : "fetch", v.addr, ack_at, ird, drd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [10];
    int n, overlap, late_ack;
    vec_t rv;

    //        dut is_d we  typ     addr          wdata          rdata          lat typ_exp
    tab[0] = '{0, 1'b0, 1'b0, 3'b000, 32'h0000_0010, 32'h0,         32'h0050_0093, 3, 3'b010};
    tab[1] = '{0, 1'b1, 1'b0, 3'b100, 32'h0000_0020, 32'h0,         32'hCAFE_F00D, 3, 3'b100};
    tab[2] = '{0, 1'b1, 1'b1, 3'b010, 32'h0000_0004, 32'hDEAD_BEEF, 32'h55AA_55AA, 3, 3'b010};
    tab[3] = '{0, 1'b1, 1'b0, 3'b001, 32'h0000_0003, 32'h0,         32'h0000_00A5, 3, 3'b001};
    tab[4] = '{1, 1'b1, 1'b0, 3'b010, 32'h0000_0008, 32'h0,         32'h1234_5678, 5, 3'b010};
    tab[5] = '{1, 1'b0, 1'b0, 3'b111, 32'h0000_0104, 32'h0,         32'h0000_0013, 5, 3'b010};
    tab[6] = '{1, 1'b1, 1'b1, 3'b001, 32'h0000_000C, 32'h0BAD_CAFE, 32'h7777_7777, 5, 3'b001};

    rst_n = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_we = 1'b0; d_type = '0;
    resp_val = '0;
    for (int d = 0; d < 2; d++) begin
      if_req_v[d] = 1'b0; d_req_v[d] = 1'b0; mem_rdata_v[d] = '0;
      age[d] = 100; exp_ird[d] = '0; exp_drd[d] = '0;
    end

    // Reset, release, idle outputs.
    repeat (3) step();
    rst_n = 1'b1;
    step();
    step();
    check_zero(0, "reset0");
    check_zero(1, "reset1");

    // Directed transaction table.
    for (int i = 0; i < 7; i++) run_txn(i, tab[i]);

    // Both requesters held high on the MEM_LAT = 1 instance.
    for (int i = 0; i < 10; i++) order[i] = 2;
    n = 0; overlap = 0;
    step();
    d_we = 1'b0; d_type = 3'b010; d_addr = 32'h40; if_addr = 32'h80; resp_val = 32'h1111_2222;
    if_req_v[0] = 1'b1; d_req_v[0] = 1'b1;
    for (int k = 0; k < 100 && n < 10; k++) begin
      step();
      if (if_ack_w[0] && d_ack_w[0]) overlap++;
      if (d_ack_w[0])  begin order[n] = 1; n++; end
      else if (if_ack_w[0]) begin order[n] = 0; n++; end
    end
    if_req_v[0] = 1'b0; d_req_v[0] = 1'b0;
    chk("streak.grants", 32'(n), 32'd10);
    chk("streak.overlap", 32'(overlap), 32'd0);
    for (int i = 0; i < 10; i++)
      chk($sformatf("streak.grant%0d", i), 32'(order[i]), (i % 5 == 4) ? 32'd0 : 32'd1);
    $display("streak order: %0d%0d%0d%0d%0d%0d%0d%0d%0d%0d (1=D 0=F)",
             order[0], order[1], order[2], order[3], order[4],
             order[5], order[6], order[7], order[8], order[9]);
    repeat (3) step();

    // Reset asserted during WAIT of a fetch on the MEM_LAT = 3 instance.
    step();
    if_addr = 32'h200; resp_val = 32'h0000_0073;
    if_req_v[1] = 1'b1;
    step();                      // issue cycle
    step();                      // first WAIT cycle
    chk("rstwait.busy_before", 32'(busy_w[1]), 32'd1);
    rst_n = 1'b0;
    if_req_v[1] = 1'b0;
    #1;
    check_zero(1, "rstwait");
    for (int d = 0; d < 2; d++) begin exp_ird[d] = '0; exp_drd[d] = '0; end
    step();
    step();
    rst_n = 1'b1;
    late_ack = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (if_ack_w[1] || d_ack_w[1]) late_ack++;
    end
    chk("rstwait.no_ack", 32'(late_ack), 32'd0);
    $display("reset-in-wait: stray acks=%0d", late_ack);
    rv = '{1, 1'b0, 1'b0, 3'b000, 32'h0000_0200, 32'h0, 32'h0000_0073, 5, 3'b010};
    run_txn(7, rv);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
